// File: rtl/cnn_pkg.sv
// Shared types and address helpers for the CNN pipeline stages (conv2d, maxpool2d, dense).
// Holds the pooling FSM state type and the channel/row/column linear-address arithmetic.
package cnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        RD3,
        CAP,
        WR,
        FIN
    } pool_state_t;

    // Row-major linear index into a CHANNELS x H x W buffer.
    function automatic int lin3(input int ch, input int r, input int c, input int h, input int w);
        return (ch * h + r) * w + c;
    endfunction

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Output-position counters (ch outer, pr, pc inner) for 2x2/stride-2 pooling.
// Produces the conv-buffer tap address, the pool-buffer write address and a last-output flag.
module pool_addr_gen
    import cnn_pkg::*;
#(
    parameter int CHANNELS = 1,
    parameter int IMG_SIZE = 4,
    parameter int OUT_SIZE = IMG_SIZE / 2,
    parameter int CONV_AW  = addr_w(CHANNELS * IMG_SIZE * IMG_SIZE),
    parameter int POOL_AW  = addr_w(CHANNELS * OUT_SIZE * OUT_SIZE)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_advance,
    input  logic [1:0]         i_tap,
    output logic [CONV_AW-1:0] o_conv_addr,
    output logic [POOL_AW-1:0] o_pool_addr,
    output logic               o_last
);

    localparam int CH_W = addr_w(CHANNELS);
    localparam int OS_W = addr_w(OUT_SIZE);

    logic [CH_W-1:0] r_ch;
    logic [OS_W-1:0] r_pr;
    logic [OS_W-1:0] r_pc;
    logic            w_last_pc;
    logic            w_last_pr;
    logic            w_last_ch;

    assign w_last_pc = (int'(r_pc) == OUT_SIZE - 1);
    assign w_last_pr = (int'(r_pr) == OUT_SIZE - 1);
    assign w_last_ch = (int'(r_ch) == CHANNELS - 1);
    assign o_last    = w_last_pc && w_last_pr && w_last_ch;

    // Counters wrap to zero after the final output, so the next pass starts clean.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ch <= '0;
            r_pr <= '0;
            r_pc <= '0;
        end else if (i_advance) begin
            if (w_last_pc) begin
                r_pc <= '0;
                if (w_last_pr) begin
                    r_pr <= '0;
                    r_ch <= w_last_ch ? '0 : r_ch + 1'b1;
                end else begin
                    r_pr <= r_pr + 1'b1;
                end
            end else begin
                r_pc <= r_pc + 1'b1;
            end
        end
    end

    // Tap bit 1 selects the lower row of the window, bit 0 the right column.
    assign o_conv_addr = CONV_AW'(lin3(int'(r_ch),
                                       2 * int'(r_pr) + int'(i_tap[1]),
                                       2 * int'(r_pc) + int'(i_tap[0]),
                                       IMG_SIZE, IMG_SIZE));
    assign o_pool_addr = POOL_AW'(lin3(int'(r_ch), int'(r_pr), int'(r_pc), OUT_SIZE, OUT_SIZE));

endmodule

// File: rtl/maxpool2d.sv
// 2x2 stride-2 signed max pooling from the conv buffer into the pool buffer, one pass per start.
// Define MAXPOOL_FUSED_RELU_EN to clamp negative pooled values to zero on write.
module maxpool2d
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 0,
    parameter int CHANNELS   = 1,
    parameter int IMG_SIZE   = 4,
    localparam int OUT_SIZE  = IMG_SIZE / 2,
    localparam int CONV_AW   = addr_w(CHANNELS * IMG_SIZE * IMG_SIZE),
    localparam int POOL_AW   = addr_w(CHANNELS * OUT_SIZE * OUT_SIZE)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic [CONV_AW-1:0]           conv_addr,
    output logic                         conv_en,
    input  logic signed [DATA_WIDTH-1:0] conv_q,
    output logic [POOL_AW-1:0]           pool_addr,
    output logic                         pool_en,
    output logic                         pool_we,
    output logic signed [DATA_WIDTH-1:0] pool_d,
    output logic                         done
);

    pool_state_t                  r_state;
    pool_state_t                  w_state_next;
    logic [1:0]                   w_tap;
    logic                         w_rd;
    logic                         w_wr;
    logic                         w_fin;
    logic                         w_last;
    logic signed [DATA_WIDTH-1:0] r_max;
    logic signed [DATA_WIDTH-1:0] r_pool_d;
    logic signed [DATA_WIDTH-1:0] w_wr_val;

    pool_addr_gen #(
        .CHANNELS (CHANNELS),
        .IMG_SIZE (IMG_SIZE),
        .OUT_SIZE (OUT_SIZE),
        .CONV_AW  (CONV_AW),
        .POOL_AW  (POOL_AW)
    ) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .i_advance   (w_wr),
        .i_tap       (w_tap),
        .o_conv_addr (conv_addr),
        .o_pool_addr (pool_addr),
        .o_last      (w_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tap        = 2'd0;
        w_rd         = 1'b0;
        w_wr         = 1'b0;
        w_fin        = 1'b0;
        case (r_state)
            IDLE: if (start) w_state_next = RD0;
            RD0: begin w_rd = 1'b1; w_tap = 2'd0; w_state_next = RD1; end
            RD1: begin w_rd = 1'b1; w_tap = 2'd1; w_state_next = RD2; end
            RD2: begin w_rd = 1'b1; w_tap = 2'd2; w_state_next = RD3; end
            RD3: begin w_rd = 1'b1; w_tap = 2'd3; w_state_next = CAP; end
            CAP: w_state_next = WR;
            WR: begin
                w_wr         = 1'b1;
                w_state_next = w_last ? FIN : RD0;
            end
            FIN: begin
                w_fin        = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // conv_q lags the read by one cycle; the first tap loads outright so all-negative windows work.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_max <= '0;
        end else if (r_state == RD1) begin
            r_max <= conv_q;
        end else if ((r_state == RD2 || r_state == RD3 || r_state == CAP) && (conv_q > r_max)) begin
            r_max <= conv_q;
        end
    end

`ifdef MAXPOOL_FUSED_RELU_EN
    assign w_wr_val = r_max[DATA_WIDTH-1] ? '0 : r_max;
`else
    assign w_wr_val = r_max;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pool_d <= '0;
        end else if (w_wr) begin
            r_pool_d <= w_wr_val;
        end
    end

    assign conv_en = w_rd;
    assign pool_en = w_wr;
    assign pool_we = w_wr;
    assign pool_d  = w_wr ? w_wr_val : r_pool_d;
    assign done    = w_fin;

endmodule

// File: tb/tb_maxpool2d.sv
// Bench for maxpool2d: a 2-channel 4x4 instance and a 1-channel 5x5 instance share start/reset.
// Directed table vectors, restart/reset sequences and random passes against a window-max model.
`timescale 1ns/1ps
module tb_maxpool2d;

    localparam int DW     = 16;
    localparam int CH_A   = 2;
    localparam int IMG_A  = 4;
    localparam int OUT_A  = 2;
    localparam int NIN_A  = 32;
    localparam int NOUT_A = 8;
    localparam int CH_B   = 1;
    localparam int IMG_B  = 5;
    localparam int OUT_B  = 2;
    localparam int NOUT_B = 4;
    localparam int DONE_A = 6 * CH_A * OUT_A * OUT_A + 1;
    localparam int DONE_B = 6 * CH_B * OUT_B * OUT_B + 1;

    localparam logic [127:0] EXP_ASC_A = {16'd116, 16'd114, 16'd108, 16'd106,
                                          16'd16, 16'd14, 16'd8, 16'd6};
    localparam logic [63:0]  EXP_ASC_B = {16'd19, 16'd17, 16'd9, 16'd7};
`ifdef MAXPOOL_FUSED_RELU_EN
    localparam logic [127:0] EXP_NEG_A = '0;
    localparam logic [63:0]  EXP_NEG_B = '0;
`else
    localparam logic [127:0] EXP_NEG_A = {16'(-111), 16'(-109), 16'(-103), 16'(-101),
                                          16'(-11), 16'(-9), 16'(-3), 16'(-1)};
    localparam logic [63:0]  EXP_NEG_B = {16'(-13), 16'(-11), 16'(-3), 16'(-1)};
`endif

    typedef struct packed {
        logic [7:0]   pat;
        logic [7:0]   rp1;
        logic [7:0]   rp2;
        logic [127:0] exp_a;
        logic [63:0]  exp_b;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;

    logic [4:0]           a_conv_addr;
    logic                 a_conv_en;
    logic signed [DW-1:0] a_conv_q = '0;
    logic [2:0]           a_pool_addr;
    logic                 a_pool_en, a_pool_we;
    logic signed [DW-1:0] a_pool_d;
    logic                 a_done;

    logic [4:0]           b_conv_addr;
    logic                 b_conv_en;
    logic signed [DW-1:0] b_conv_q = '0;
    logic [1:0]           b_pool_addr;
    logic                 b_pool_en, b_pool_we;
    logic signed [DW-1:0] b_pool_d;
    logic                 b_done;

    int img_a[64];
    int img_b[64];
    int pool_a[NOUT_A];
    int pool_b[NOUT_B];
    int a_wr_total = 0, b_wr_total = 0, a_wr_base = 0, b_wr_base = 0;
    int a_order_err = 0, b_order_err = 0, b_edge_rd = 0, rd_total = 0;
    int n_checks = 0, n_err = 0;

    always #5 clk = ~clk;

    maxpool2d #(.DATA_WIDTH(DW), .FRAC_BITS(0), .CHANNELS(CH_A), .IMG_SIZE(IMG_A)) u_dut_a (
        .clk(clk), .reset(rst_n), .start(start),
        .conv_addr(a_conv_addr), .conv_en(a_conv_en), .conv_q(a_conv_q),
        .pool_addr(a_pool_addr), .pool_en(a_pool_en), .pool_we(a_pool_we),
        .pool_d(a_pool_d), .done(a_done)
    );

    maxpool2d #(.DATA_WIDTH(DW), .FRAC_BITS(0), .CHANNELS(CH_B), .IMG_SIZE(IMG_B)) u_dut_b (
        .clk(clk), .reset(rst_n), .start(start),
        .conv_addr(b_conv_addr), .conv_en(b_conv_en), .conv_q(b_conv_q),
        .pool_addr(b_pool_addr), .pool_en(b_pool_en), .pool_we(b_pool_we),
        .pool_d(b_pool_d), .done(b_done)
    );

    // Conv buffers (1-cycle synchronous read) and pool buffers with write-order tracking.
    always @(posedge clk) begin
        if (a_conv_en) a_conv_q <= DW'(img_a[a_conv_addr]);
        if (b_conv_en) b_conv_q <= DW'(img_b[b_conv_addr]);
        if (a_conv_en || b_conv_en) rd_total <= rd_total + 1;
        if (b_conv_en && ((int'(b_conv_addr) % IMG_B) == IMG_B - 1 || (int'(b_conv_addr) / IMG_B) >= IMG_B - 1))
            b_edge_rd <= b_edge_rd + 1;
        if (a_pool_en && a_pool_we) begin
            pool_a[a_pool_addr] <= int'(a_pool_d);
            if (int'(a_pool_addr) != a_wr_total - a_wr_base) a_order_err <= a_order_err + 1;
            a_wr_total <= a_wr_total + 1;
        end
        if (b_pool_en && b_pool_we) begin
            pool_b[b_pool_addr] <= int'(b_pool_d);
            if (int'(b_pool_addr) != b_wr_total - b_wr_base) b_order_err <= b_order_err + 1;
            b_wr_total <= b_wr_total + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int rnd(input int mode);
        logic [15:0] t;
        t = 16'($urandom);
        case (mode)
            3:       return -1 - int'($urandom_range(0, 32767));
            4:       return int'($urandom_range(0, 6)) - 3;
            default: return int'($signed(t));
        endcase
    endfunction

    task automatic fill(input int pat);
        for (int i = 0; i < 64; i++) begin
            img_a[i] = 0;
            img_b[i] = 0;
        end
        for (int i = 0; i < NIN_A; i++) begin
            case (pat)
                0:       img_a[i] = (i < 16) ? i + 1 : i - 16 + 101;
                1:       img_a[i] = (i < 16) ? -(i + 1) : -(i - 16 + 101);
                default: img_a[i] = rnd(pat);
            endcase
        end
        for (int i = 0; i < IMG_B * IMG_B; i++) begin
            case (pat)
                0:       img_b[i] = i + 1;
                1:       img_b[i] = -(i + 1);
                default: img_b[i] = rnd(pat);
            endcase
        end
    endtask

    // Max of the four pixels of the 2x2 window at output (ch, pr, pc) of an n x n map.
    function automatic int ref_pool(input int img[64], input int n, input int ch, input int pr, input int pc);
        int win[4];
        int m;
        win[0] = img[(ch * n + 2 * pr) * n + 2 * pc];
        win[1] = img[(ch * n + 2 * pr) * n + 2 * pc + 1];
        win[2] = img[(ch * n + 2 * pr + 1) * n + 2 * pc];
        win[3] = img[(ch * n + 2 * pr + 1) * n + 2 * pc + 1];
        m = win[0];
        foreach (win[i]) if (win[i] > m) m = win[i];
`ifdef MAXPOOL_FUSED_RELU_EN
        if (m < 0) m = 0;
`endif
        return m;
    endfunction

    // Called #1 after a rising edge; start is sampled on the next edge, so k=1 is the first RD0 cycle.
    task automatic run_pass(input int rp1, input int rp2, input logic [127:0] ea, input logic [63:0] eb,
                            input string tag);
        int adc, bdc, adn, bdn, a_ord0, b_ord0, b_edge0;
        adc = -1; bdc = -1; adn = 0; bdn = 0;
        a_wr_base = a_wr_total;
        b_wr_base = b_wr_total;
        a_ord0 = a_order_err;
        b_ord0 = b_order_err;
        b_edge0 = b_edge_rd;
        start = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            start = ((k == rp1) || (k == rp2)) ? 1'b1 : 1'b0;
            if (a_done) begin adn++; if (adc < 0) adc = k; end
            if (b_done) begin bdn++; if (bdc < 0) bdc = k; end
        end
        start = 1'b0;
        for (int i = 0; i < NOUT_A; i++)
            check($sformatf("%s pool_a[%0d]", tag, i), pool_a[i], int'($signed(ea[i*16 +: 16])));
        for (int i = 0; i < NOUT_B; i++)
            check($sformatf("%s pool_b[%0d]", tag, i), pool_b[i], int'($signed(eb[i*16 +: 16])));
        check({tag, " done cycle A"}, adc, DONE_A);
        check({tag, " done cycle B"}, bdc, DONE_B);
        check({tag, " done pulses A"}, adn, 1);
        check({tag, " done pulses B"}, bdn, 1);
        check({tag, " writes A"}, a_wr_total - a_wr_base, NOUT_A);
        check({tag, " writes B"}, b_wr_total - b_wr_base, NOUT_B);
        check({tag, " addr order A"}, a_order_err - a_ord0, 0);
        check({tag, " addr order B"}, b_order_err - b_ord0, 0);
        check({tag, " edge reads B"}, b_edge_rd - b_edge0, 0);
        check({tag, " pool_d hold A"}, int'(a_pool_d), int'($signed(ea[127:112])));
        check({tag, " pool_d hold B"}, int'(b_pool_d), int'($signed(eb[63:48])));
        $display("pass %s: done A@%0d B@%0d, writes A=%0d B=%0d", tag, adc, bdc,
                 a_wr_total - a_wr_base, b_wr_total - b_wr_base);
    endtask

    task automatic model_pass(input string tag);
        logic [127:0] ea;
        logic [63:0]  eb;
        for (int ch = 0; ch < CH_A; ch++)
            for (int pr = 0; pr < OUT_A; pr++)
                for (int pc = 0; pc < OUT_A; pc++)
                    ea[(ch * 4 + pr * 2 + pc) * 16 +: 16] = 16'(ref_pool(img_a, IMG_A, ch, pr, pc));
        for (int pr = 0; pr < OUT_B; pr++)
            for (int pc = 0; pc < OUT_B; pc++)
                eb[(pr * 2 + pc) * 16 +: 16] = 16'(ref_pool(img_b, IMG_B, 0, pr, pc));
        run_pass(0, 0, ea, eb, tag);
    endtask

    initial begin
        vec_t vecs[4];
        int wr0, rd0, dn;
        vecs[0] = {8'd0, 8'd0, 8'd0, EXP_ASC_A, EXP_ASC_B};
        vecs[1] = {8'd1, 8'd0, 8'd0, EXP_NEG_A, EXP_NEG_B};
        vecs[2] = {8'd0, 8'd3, 8'd12, EXP_ASC_A, EXP_ASC_B};
        vecs[3] = {8'd1, 8'd25, 8'd0, EXP_NEG_A, EXP_NEG_B};

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ctl A", int'({a_conv_addr, a_conv_en, a_pool_addr, a_pool_en, a_pool_we, a_done}), 0);
        check("reset ctl B", int'({b_conv_addr, b_conv_en, b_pool_addr, b_pool_en, b_pool_we, b_done}), 0);
        check("reset pool_d A", int'(a_pool_d), 0);
        check("reset pool_d B", int'(b_pool_d), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 4; v++) begin
            fill(int'(vecs[v].pat));
            run_pass(int'(vecs[v].rp1), int'(vecs[v].rp2), vecs[v].exp_a, vecs[v].exp_b,
                     $sformatf("vec%0d", v));
        end

        // Reset pulled low mid-pass: outputs drop at once, no activity until a new start.
        fill(2);
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check("pre-reset conv_en A", int'(a_conv_en), 1);
        rst_n = 1'b0;
        #1;
        check("abort ctl A", int'({a_conv_addr, a_conv_en, a_pool_addr, a_pool_en, a_pool_we, a_done}), 0);
        check("abort ctl B", int'({b_conv_addr, b_conv_en, b_pool_addr, b_pool_en, b_pool_we, b_done}), 0);
        check("abort pool_d A", int'(a_pool_d), 0);
        check("abort pool_d B", int'(b_pool_d), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr0 = a_wr_total + b_wr_total;
        rd0 = rd_total;
        dn = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (a_done || b_done) dn++;
        end
        check("post-abort done", dn, 0);
        check("post-abort writes", a_wr_total + b_wr_total - wr0, 0);
        check("post-abort reads", rd_total - rd0, 0);
        $display("reset abort: done=%0d writes=%0d reads=%0d", dn, a_wr_total + b_wr_total - wr0, rd_total - rd0);

        for (int r = 0; r < 6; r++) begin
            fill(2 + (r % 3));
            model_pass($sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/maxpool2d.md
Name: maxpool2d

Overview:
- Reader/consumer of the conv output buffer that conv2d writes.
- Performs 2x2, stride-2 signed max pooling per channel.
- Reads the conv buffer through the same 1-cycle-latency synchronous read port style conv2d uses on the ifmap side.
- Writes pooled results to a pool buffer; sits between conv2d (plus its buffer) and the dense stage; runs once per start pulse.

Parameters:
- DATA_WIDTH, 16, signed sample width.
- FRAC_BITS, 0, fixed-point fraction bits; carried for interface uniformity only, since max is scale-invariant.
- CHANNELS, 1, number of feature-map channels.
- IMG_SIZE, 4, input height/width (square). OUT_SIZE = IMG_SIZE/2 (floor).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins a pooling pass when idle
- conv_addr  out  clog2(CHANNELS*IMG_SIZE*IMG_SIZE) (min 1)  conv buffer read address
- conv_en  out  1  conv buffer read enable
- conv_q  in  DATA_WIDTH  read data; valid the cycle after conv_en
- pool_addr  out  clog2(CHANNELS*OUT_SIZE*OUT_SIZE) (min 1)  pool buffer address
- pool_en  out  1  pool buffer enable
- pool_we  out  1  pool buffer write enable
- pool_d  out  DATA_WIDTH  pooled value
- done  out  1  single-cycle pulse after the final write

Behaviour:
- Reset: clk and reset only; reset is asynchronous, active-low. While reset is low, all outputs are 0, the FSM is in IDLE, and counters and the max register are cleared.
- Linear address: (ch*N + r)*N + c, with N = IMG_SIZE for reads and N = OUT_SIZE for writes.
- Iteration order: ch outer, pr middle, pc inner (row-major), matching conv2d's write order.
- FSM states: IDLE, RD0, RD1, RD2, RD3, CAP, WR, FIN.
  - IDLE: start=1 goes to RD0. Otherwise stay.
  - RDk (k=0..3): conv_en=1. conv_addr takes the window taps in this order: (2pr,2pc), (2pr,2pc+1), (2pr+1,2pc), (2pr+1,2pc+1).
  - Capture: in RD1, RD2, RD3 and CAP, sample conv_q; that value is the data from the previous state's read. The first sample loads max outright (no initial 0, so all-negative windows are correct). Later samples use max <= (conv_q > max) ? conv_q : max, a signed compare.
  - CAP: conv_en=0; capture the 4th sample.
  - WR: pool_en=pool_we=1, pool_addr = current output index, pool_d = max (combinationally including nothing new). Then advance pc/pr/ch. If more outputs remain, go to RD0; otherwise go to FIN.
  - FIN: done=1 for one cycle, then IDLE.
- Timing: exactly 6 cycles per output. With the first RD0 counted as cycle 1, done is high in cycle 6*CHANNELS*OUT_SIZE^2 + 1.
- Output qualification: conv_en is 0 outside RDk; pool_en and pool_we are 0 outside WR. pool_d is held at its last value outside WR.
- Start while not IDLE (including the FIN cycle): ignored, no restart, no queuing.
- Odd IMG_SIZE: the last row and column are never read (floor).
- Reset asserted mid-pass: immediate abort. No further reads, writes or done. A fresh start is required after reset releases.
- No arithmetic growth: the output has the same width as the input and needs no saturation.

Optional Feature:
- Macro: MAXPOOL_FUSED_RELU_EN.
- Defined: the value written in WR is max<0 ? 0 : max, i.e. ReLU fused into pooling. Cycle timing is unchanged.
- Undefined: the raw signed max is written, so negative results pass through.

Decomposition:
- Shared package cnn_pkg:
  - pool FSM state enum (pool_state_t);
  - lin3 address function (ch, r, c, H, W);
  - clog2-with-min-1 address width helper.
- One sub-module, pool_addr_gen:
  - ch/pr/pc counters;
  - tap-offset mux producing conv_addr and pool_addr;
  - last-output flag.
- The FSM and max register stay in maxpool2d.

Test Plan:
- Values 1..16, CHANNELS=1, IMG_SIZE=4 -> pool = [6,8,14,16]; done high exactly in cycle 25 after start.
- All-negative values -1..-16 -> pool = [-1,-3,-9,-11]. With MAXPOOL_FUSED_RELU_EN -> [0,0,0,0].
- CHANNELS=2, IMG_SIZE=4, ch1 = ch0+100 -> ch0 = [6,8,14,16], ch1 = [106,108,114,116]; pool_addr runs 0..7 in order.
- IMG_SIZE=5, values 1..25 -> [7,9,17,19]; row 4 and column 4 are never addressed, checked by asserting conv_addr never decodes r=4 or c=4.
- Start re-pulsed in cycles 3 and 12 of a pass -> results and done timing identical to a single start; exactly one done pulse.
- reset low for 2 cycles at cycle 10 -> outputs are 0 immediately, no done; a new start then yields correct full results.
